// File: rtl/kypd_matrix_scan.sv
// Column-scanned ROWS x COLS active-low key matrix with per-key debounce and a press/release event FIFO.
// Events are offered first-word-fall-through on ev_valid/ev_ready; a full FIFO drops new events and flags ev_overflow.
module kypd_matrix_scan #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int NK        = ROWS * COLS,
    localparam int KW        = (NK > 1) ? $clog2(NK) : 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [COLS-1:0] col_n,
    input  logic [ROWS-1:0] row_n,
    output logic [NK-1:0]   keys,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [KW-1:0]   ev_key,
    output logic            ev_press,
    output logic            ev_overflow,
    input  logic            ev_ovf_clr,
    output logic            scan_done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {DWELL, SAMPLE, PROC} state_t;

    typedef struct packed {
        logic [KW-1:0] key;
        logic          press;
    } ev_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   dwell;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [ROWS-1:0] raw;
    logic [BW-1:0]   cnt [NK];

    logic            dwell_last;
    logic            proc_last;
    logic [KW-1:0]   key_idx;
    logic            differ;
    logic [BW-1:0]   cnt_inc;
    logic            accept;

    logic [PW:0]     wr_ptr, rd_ptr;
    ev_t             mem [FIFO_DEPTH];
    ev_t             head;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;

    assign col_n = ~(COLS'(1) << col);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DWELL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dwell_last = (dwell == DW'(SCAN_DIV - ROWS - 2));
        proc_last  = (row == RW'(ROWS - 1));
        key_idx    = KW'(int'(row) * COLS + int'(col));
        differ     = (raw[row] != keys[key_idx]);
        cnt_inc    = cnt[key_idx] + BW'(1);
        accept     = 1'b0;
        case (state)
            DWELL:   if (dwell_last) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = PROC;
            PROC: begin
                accept = differ && (cnt_inc == BW'(DEBOUNCE));
                if (proc_last) state_nxt = DWELL;
            end
            default: state_nxt = DWELL;
        endcase
    end

    // Scan datapath: one key debounced per PROC cycle, column advances as PROC ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell     <= '0;
            col       <= '0;
            row       <= '0;
            raw       <= '0;
            keys      <= '0;
            scan_done <= 1'b0;
            for (int i = 0; i < NK; i++) cnt[i] <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                DWELL: dwell <= dwell_last ? '0 : dwell + DW'(1);
                SAMPLE: begin
                    raw <= ~row_n;
                    row <= '0;
                end
                PROC: begin
                    if (!differ) begin
                        cnt[key_idx] <= '0;
                    end else if (accept) begin
                        keys[key_idx] <= ~keys[key_idx];
                        cnt[key_idx]  <= '0;
                    end else begin
                        cnt[key_idx] <= cnt_inc;
                    end
                    if (proc_last) begin
                        row <= '0;
                        if (col == CW'(COLS - 1)) begin
                            col       <= '0;
                            scan_done <= 1'b1;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign fifo_full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ev_valid  = (wr_ptr != rd_ptr);
    assign pop       = ev_valid && ev_ready;
    assign push      = accept && (!fifo_full || pop);
    assign drop      = accept && fifo_full && !pop;
    assign head      = mem[rd_ptr[PW-1:0]];
    assign ev_key    = head.key;
    assign ev_press  = head.press;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ev_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
            if (drop)
                ev_overflow <= 1'b1;
            else if (ev_ovf_clr)
                ev_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= '{key: key_idx, press: ~keys[key_idx]};
    end

endmodule

// File: tb/tb_kypd_matrix_scan.sv
// Scoreboarded bench for kypd_matrix_scan: 4x4 matrix, 8-cycle dwell, debounce 3, 4-entry event FIFO.
module tb_kypd_matrix_scan;

    typedef struct packed {
        logic [3:0] key;
        logic       press;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] keys;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_key;
    logic        ev_press;
    logic        ev_overflow;
    logic        ev_ovf_clr;
    logic        scan_done;

    logic [15:0] pressed;
    logic [15:0] exp_keys;
    ev_t         exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    kypd_matrix_scan #(
        .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .keys(keys),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key), .ev_press(ev_press),
        .ev_overflow(ev_overflow), .ev_ovf_clr(ev_ovf_clr), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = '1;
        for (int c = 0; c < 4; c++)
            if (!col_n[c])
                for (int r = 0; r < 4; r++)
                    if (pressed[r*4 + c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: got key %0d press %0b, none expected", ev_key, ev_press);
            end else begin
                e = exp_q.pop_front();
                check("event_key", 32'(ev_key), 32'(e.key));
                check("event_press", 32'(ev_press), 32'(e.press));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic next_frame();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (scan_done) return;
        end
        compared++;
        mismatched++;
        $display("FAIL frame_timeout: got no scan_done in 40 cycles, expected one every 32");
    endtask

    task automatic frames(input int n);
        repeat (n) next_frame();
    endtask

    task automatic set_key(input int k, input logic v, input bit expect_ev);
        ev_t e;
        pressed[k]  = v;
        exp_keys[k] = v;
        if (expect_ev) begin
            e.key   = 4'(k);
            e.press = v;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        int          sd_count;
        logic [3:0]  exp_col;
        logic [4:0]  bseq;
        int          grp[6];

        rst        = 1'b1;
        pressed    = '0;
        exp_keys   = '0;
        ev_ready   = 1'b1;
        ev_ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and one full frame of column stepping
        check("rst_col_n", 32'(col_n), 32'hE);
        check("rst_keys", 32'(keys), 32'h0);
        check("rst_ev_valid", 32'(ev_valid), 32'h0);
        check("rst_ev_overflow", 32'(ev_overflow), 32'h0);
        check("rst_scan_done", 32'(scan_done), 32'h0);
        sd_count = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((k / 8) % 4));
            check("col_n_step", 32'(col_n), 32'(exp_col));
            if (scan_done) sd_count++;
        end
        check("scan_done_pulses", 32'(sd_count), 32'd1);

        // Single press/release of key 6 (row 1, column 2)
        set_key(6, 1'b1, 1'b1);
        frames(2);
        check("press_not_early", 32'(keys[6]), 32'h0);
        frames(1);
        check("press_keys", 32'(keys), 32'(exp_keys));
        check("press_drained", 32'(exp_q.size()), 32'd0);
        set_key(6, 1'b0, 1'b1);
        frames(3);
        check("release_keys", 32'(keys), 32'(exp_keys));
        check("release_drained", 32'(exp_q.size()), 32'd0);

        // Bounce on key 5: two disagreeing samples, one agreeing, two disagreeing, then settle
        bseq = 5'b11011;
        for (int i = 0; i < 5; i++) begin
            pressed[5] = bseq[i];
            next_frame();
        end
        pressed[5] = 1'b0;
        frames(3);
        check("bounce_keys", 32'(keys), 32'(exp_keys));
        check("bounce_no_event", 32'(ev_valid), 32'h0);

        // Column 0 plus key 3 pressed together; events come out column-major, row ascending
        set_key(0, 1'b1, 1'b1);
        set_key(4, 1'b1, 1'b1);
        set_key(8, 1'b1, 1'b1);
        set_key(12, 1'b1, 1'b1);
        set_key(3, 1'b1, 1'b1);
        frames(3);
        check("multi_press_keys", 32'(keys), 32'(exp_keys));
        check("multi_press_drained", 32'(exp_q.size()), 32'd0);
        set_key(0, 1'b0, 1'b1);
        set_key(4, 1'b0, 1'b1);
        set_key(8, 1'b0, 1'b1);
        set_key(12, 1'b0, 1'b1);
        set_key(3, 1'b0, 1'b1);
        frames(3);
        check("multi_release_keys", 32'(keys), 32'(exp_keys));
        check("multi_release_drained", 32'(exp_q.size()), 32'd0);

        // Overflow: six presses into a 4-deep FIFO with the consumer stalled
        ev_ready = 1'b0;
        grp = '{1, 5, 9, 2, 6, 10};
        for (int i = 0; i < 6; i++) set_key(grp[i], 1'b1, i < 4);
        frames(3);
        check("ovf_flag", 32'(ev_overflow), 32'h1);
        check("ovf_keys", 32'(keys), 32'(exp_keys));
        check("ovf_valid", 32'(ev_valid), 32'h1);
        ev_ovf_clr = 1'b1;
        cycles(1);
        ev_ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ev_overflow), 32'h0);
        ev_ready = 1'b1;
        cycles(8);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_empty", 32'(ev_valid), 32'h0);
        for (int i = 0; i < 6; i++) set_key(grp[i], 1'b0, 1'b1);
        frames(3);
        check("ovf_release_keys", 32'(keys), 32'(exp_keys));
        check("ovf_release_drained", 32'(exp_q.size()), 32'd0);

        // Reset during PROC with two events queued; held keys must re-report afterwards
        ev_ready = 1'b0;
        set_key(0, 1'b1, 1'b0);
        set_key(4, 1'b1, 1'b0);
        frames(3);
        cycles(5);
        check("queued_before_reset", 32'(ev_valid), 32'h1);
        rst = 1'b1;
        exp_q.delete();
        cycles(1);
        check("midrst_ev_valid", 32'(ev_valid), 32'h0);
        check("midrst_keys", 32'(keys), 32'h0);
        check("midrst_col_n", 32'(col_n), 32'hE);
        rst = 1'b0;
        set_key(0, 1'b1, 1'b1);
        set_key(4, 1'b1, 1'b1);
        ev_ready = 1'b1;
        cycles(63);
        check("rereport_not_early", 32'(keys), 32'h0);
        cycles(10);
        check("rereport_keys", 32'(keys), 32'(exp_keys));
        cycles(10);
        check("rereport_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/kypd_matrix_scan.md
Name: kypd_matrix_scan

Overview:
Parametrised successor to the team's fixed 4x4 PmodKYPD multi-input controller. Scans a ROWS x COLS active-low key matrix one column at a time and debounces every key independently. Publishes a live debounced key-state vector plus a FIFO of press/release events with a valid/ready handshake. Sits between the Pmod GPIO pins and downstream consumers such as UART, display or control FSMs.

Parameters:
ROWS, 4, number of matrix rows (row_n inputs), 1..8
COLS, 4, number of matrix columns (col_n outputs), 1..8
SCAN_DIV, 50000, clk cycles each column is driven (dwell); must be >= ROWS+2
DEBOUNCE, 4, consecutive disagreeing samples needed to accept a key change, >= 1
FIFO_DEPTH, 8, event FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-high
col_n  out  COLS  column drive, active low, exactly one bit low outside reset
row_n  in  ROWS  row sense, active low (pulled up on board)
keys  out  ROWS*COLS  debounced state, 1 = pressed; bit index = r*COLS + c
ev_valid  out  1  event FIFO non-empty
ev_ready  in  1  consumer accepts head event when ev_valid & ev_ready
ev_key  out  $clog2(ROWS*COLS) (min 1)  key index of head event
ev_press  out  1  1 = press, 0 = release
ev_overflow  out  1  sticky: an event was dropped because the FIFO was full
ev_ovf_clr  in  1  clears ev_overflow
scan_done  out  1  one-cycle pulse when the last column's rows finish processing

Behaviour:
- Reset values: col_n = ~1 (column 0 low); dwell counter 0; keys = 0; all debounce counters 0; FIFO empty; ev_valid 0; ev_overflow 0; scan_done 0. Reset mid-dwell or mid-processing aborts everything and applies these values on the next edge. Queued events are lost.
- Scan FSM states: DWELL, SAMPLE, PROC.
  - DWELL: counts cycles 0..SCAN_DIV-ROWS-2 with the current column driven.
  - SAMPLE (1 cycle): registers raw = ~row_n.
  - PROC: ROWS cycles, row pointer r = 0..ROWS-1, handles key (r, c) each cycle.
  - After PROC the column advances: c = COLS-1 wraps to 0 and scan_done pulses on that wrap. col_n changes on the same edge the FSM returns to DWELL.
  - Column period is exactly SCAN_DIV cycles; frame period is COLS*SCAN_DIV.
- Per-key debounce, in PROC for key k:
  - raw[r] == keys[k]: cnt[k] <= 0.
  - Otherwise cnt[k] increments. When the incremented value equals DEBOUNCE: keys[k] toggles, cnt[k] <= 0, and an event {k, new state} is pushed.
  - DEBOUNCE = 1 means the change is accepted on the first differing sample.
  - A bounce (agreeing sample) before reaching DEBOUNCE resets cnt to 0.
- Event order: at most one push per cycle. Events are ordered by column (ascending, wrapping) and then by row ascending.
- FIFO: first-word-fall-through; ev_key/ev_press are valid whenever ev_valid = 1 and are held stable until popped.
  - Pop occurs when ev_valid & ev_ready.
  - A push while full with no pop in the same cycle drops the event and sets ev_overflow; keys still updates.
  - Push and pop in the same cycle while full: both succeed.
  - Pop when empty has no effect.
- ev_overflow: ev_ovf_clr clears it. If a set and a clear occur in the same cycle, the set wins.
- keys and events are consistent: keys[k] updates on the same edge its event is pushed or dropped.
- Simultaneous presses: any combination is reported; no ghost rejection (board has no diodes), which is a documented limitation.

Test Plan:
(Bench uses ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4; frame = 32 cycles.)
- Reset check: rst high, then low -> col_n = 4'b1110; after 8 cycles col_n = 4'b1101; after 32 cycles back to 4'b1110 with one scan_done pulse; keys = 0; ev_valid = 0.
- Single press: hold key r=1,c=2 low -> keys[6] sets within 3 frames (<= 96+8 cycles) and exactly one event {6, press} appears. Release -> one event {6, release}; keys[6] clears.
- Bounce: key 5 disagrees on 2 samples, agrees on 1, then disagrees on 2 -> no event and keys[5] stays 0.
- Simultaneous keys: keys 0, 4, 8, 12 (column 0) and key 3 pressed together, ev_ready = 1 -> events in order 0, 4, 8, 12, 3, all press.
- Overflow: ev_ready = 0, press 6 distinct keys -> 4 events queued and ev_overflow = 1; keys shows all 6 pressed. Pulse ev_ovf_clr -> ev_overflow clears. Drain -> the first 4 events come out in order.
- Reset mid-operation: assert rst during PROC with 2 events queued -> ev_valid = 0, keys = 0, col_n = 4'b1110 on the next edge; a held key re-reports a press after 3 frames.
